vpg_mode_sequencer: RTL and testbench

//  Sequences video-mode changes for the VPG. Blanks the picture, pulses mode/mode_change to
//  pll_controller, waits for the pixel PLL to relock and releases blank. Sits in clk_50

---
 rtl/vpg_pkg.sv | 34 +++
 rtl/vpg_lock_monitor.sv | 39 +++
 rtl/vpg_mode_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_vpg_mode_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpg_pkg.sv
// Shared types for the VPG mode sequencer: FSM state encoding, mode codes
// (mirroring vpg.h) and counter sizing helpers.
package vpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_BLANK       = 3'd1,
        ST_REQ         = 3'd2,
        ST_WAIT_UNLOCK = 3'd3,
        ST_WAIT_LOCK   = 3'd4,
        ST_UNBLANK     = 3'd5,
        ST_FAIL        = 3'd6
    } vpg_state_t;

    localparam logic [3:0] VGA_640x480p60 = 4'd0;
    localparam logic [3:0] MODE_720x480   = 4'd1;
    localparam logic [3:0] MODE_1024x768  = 4'd2;
    localparam logic [3:0] MODE_1280x1024 = 4'd3;
    localparam logic [3:0] MODE_1920x1080 = 4'd4;
    localparam logic [3:0] MODE_1440x900  = 4'd5;

    // Enough bits to hold max_val with one bit of headroom for saturation.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vpg_lock_monitor.sv
// Synchronises the asynchronous pixel-PLL lock and qualifies it: lock_ok is
// high on the LOCK_STABLE-th consecutive synchronised-locked cycle.
module vpg_lock_monitor
    import vpg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_locked,
    input  logic clear,
    output logic locked_s,
    output logic lock_ok
);

    localparam int unsigned SW = cnt_width(LOCK_STABLE);

    logic          sync_q;
    logic [SW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 1'b0;
            locked_s   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
            // Count prior consecutive locked cycles; saturates one short of the goal.
            if (clear || !locked_s)
                stable_cnt <= '0;
            else if (stable_cnt != SW'(LOCK_STABLE - 1))
                stable_cnt <= stable_cnt + SW'(1);
        end
    end

    assign lock_ok = locked_s && (stable_cnt == SW'(LOCK_STABLE - 1));

endmodule

// File: rtl/vpg_mode_sequencer.sv
// Sequences VPG mode changes: blank, pulse mode_change to the PLL controller,
// wait for relock with retry/safe-mode fallback, unblank.
// Optional one-entry request buffer: define VPG_MODE_SEQ_QUEUE_EN.
module vpg_mode_sequencer
    import vpg_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES   = 1000000,
    parameter int unsigned UNLOCK_TIMEOUT = 5000,
    parameter int unsigned LOCK_TIMEOUT   = 2500000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned MAX_RETRY      = 2,
    parameter logic [3:0]  RESET_MODE     = VGA_640x480p60,
    parameter logic [3:0]  SAFE_MODE      = VGA_640x480p60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_mode,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       vpg_blank,
    output logic       busy,
    output logic       done,
    output logic       err,
    output vpg_state_t state_dbg
);

    // Handshake: a request transfers on a rising edge with req_valid & req_ready;
    // req_valid and req_mode stay stable until then. req_ready never depends on req_valid.

    localparam int unsigned TW = cnt_width(max3(BLANK_CYCLES, UNLOCK_TIMEOUT, LOCK_TIMEOUT));
    localparam int unsigned RW = cnt_width(MAX_RETRY);

    vpg_state_t    state, state_n;
    logic [TW-1:0] timer;
    logic [3:0]    target, target_n, mode_n;
    logic [RW-1:0] retry, retry_n;
    logic          fallback, fallback_n, err_n;
    logic          same_done, same_done_n;
    logic          locked_s, lock_ok;
    logic          idle_like, req_take;
    logic [3:0]    take_mode;

    assign idle_like = (state == ST_IDLE) || (state == ST_FAIL);

`ifdef VPG_MODE_SEQ_QUEUE_EN
    logic       pend_valid;
    logic [3:0] pend_mode;

    assign req_ready = !pend_valid;
    assign req_take  = idle_like && (pend_valid || req_valid);
    assign take_mode = pend_valid ? pend_mode : req_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_mode  <= '0;
        end else if (pend_valid && idle_like) begin
            pend_valid <= 1'b0;
        end else if (req_valid && !pend_valid && !idle_like) begin
            pend_valid <= 1'b1;
            pend_mode  <= req_mode;
        end
    end
`else
    assign req_ready = idle_like;
    assign req_take  = idle_like && req_valid;
    assign take_mode = req_mode;
`endif

    vpg_lock_monitor #(.LOCK_STABLE(LOCK_STABLE)) u_lock (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .clear      (state != ST_WAIT_LOCK),
        .locked_s   (locked_s),
        .lock_ok    (lock_ok)
    );

    always_comb begin
        state_n     = state;
        target_n    = target;
        retry_n     = retry;
        fallback_n  = fallback;
        err_n       = err;
        mode_n      = mode;
        same_done_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_take && take_mode != mode) begin
                    target_n   = take_mode;
                    retry_n    = '0;
                    fallback_n = 1'b0;
                    state_n    = ST_BLANK;
                end else begin
                    same_done_n = req_take;
                    // Lock loss re-enters the relock path for the mode already in use.
                    if (!locked_s) begin
                        target_n = mode;
                        retry_n  = '0;
                        state_n  = ST_WAIT_LOCK;
                    end
                end
            end
            ST_BLANK: if (timer == TW'(BLANK_CYCLES - 1)) state_n = ST_REQ;
            ST_REQ: begin
                mode_n  = target;
                state_n = ST_WAIT_UNLOCK;
            end
            ST_WAIT_UNLOCK: begin
                if (!locked_s || timer == TW'(UNLOCK_TIMEOUT - 1)) state_n = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_n = ST_UNBLANK;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_n = retry + RW'(1);
                        state_n = ST_REQ;
                    end else if (target != SAFE_MODE) begin
                        target_n   = SAFE_MODE;
                        err_n      = 1'b1;
                        fallback_n = 1'b1;
                        retry_n    = '0;
                        state_n    = ST_REQ;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_FAIL;
                    end
                end
            end
            ST_UNBLANK: begin
                if (!fallback) err_n = 1'b0;
                state_n = ST_IDLE;
            end
            ST_FAIL: begin
                err_n = 1'b1;
                if (req_take) begin
                    target_n   = take_mode;
                    retry_n    = '0;
                    fallback_n = 1'b0;
                    state_n    = ST_BLANK;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_LOCK;
            timer       <= '0;
            target      <= RESET_MODE;
            retry       <= '0;
            fallback    <= 1'b0;
            err         <= 1'b0;
            mode        <= RESET_MODE;
            mode_change <= 1'b0;
            same_done   <= 1'b0;
        end else begin
            state       <= state_n;
            // Timer restarts on every state change so each timeout counts from entry.
            timer       <= (state_n != state) ? '0 : ((timer == '1) ? timer : timer + TW'(1));
            target      <= target_n;
            retry       <= retry_n;
            fallback    <= fallback_n;
            err         <= err_n;
            mode        <= mode_n;
            mode_change <= (state == ST_REQ);
            same_done   <= same_done_n;
        end
    end

    assign vpg_blank = !((state == ST_IDLE) || (state == ST_UNBLANK));
    assign busy      = !idle_like;
    assign done      = same_done || (state == ST_UNBLANK);
    assign state_dbg = state;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Directed bench for vpg_mode_sequencer: a per-cycle vector table for reset,
// initial lock and a same-mode request, then hand-written multi-cycle sequences.
module tb_vpg_mode_sequencer;
  import vpg_pkg::*;

`ifdef VPG_MODE_SEQ_QUEUE_EN
  localparam bit Q_RDY = 1'b1;
`else
  localparam bit Q_RDY = 1'b0;
`endif

  // observed word: {blank, busy, done, ready, mode_change, err, mode}
  localparam logic [9:0] O_WL  = {1'b1, 1'b1, 1'b0, Q_RDY, 1'b0, 1'b0, 4'd0};
  localparam logic [9:0] O_UB  = {1'b0, 1'b1, 1'b1, Q_RDY, 1'b0, 1'b0, 4'd0};
  localparam logic [9:0] O_ID  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
  localparam logic [9:0] O_IDD = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
  localparam logic [9:0] O_FL  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};

  typedef struct {
    logic       rst;
    logic       lk;
    logic       rv;
    logic [3:0] rm;
    logic [9:0] exp_o;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_mode = 4'd0;
  logic       req_valid = 1'b0;
  logic       pll_locked = 1'b1;
  logic       req_ready, mode_change, vpg_blank, busy, done, err;
  logic [3:0] mode;
  vpg_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int blank_cycles = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_m;
  vec_t vecs [0:10];

  vpg_mode_sequencer #(
    .BLANK_CYCLES(8), .UNLOCK_TIMEOUT(4), .LOCK_TIMEOUT(16), .LOCK_STABLE(3), .MAX_RETRY(1)
  ) dut (
    .clk(clk), .reset(reset), .req_mode(req_mode), .req_valid(req_valid),
    .req_ready(req_ready), .pll_locked(pll_locked), .mode(mode),
    .mode_change(mode_change), .vpg_blank(vpg_blank), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] obs();
    return {vpg_blank, busy, done, req_ready, mode_change, err, mode};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every mode_change pulse must match the next expected mode
  always @(negedge clk) begin
    if (!reset) begin
      if (mode_change) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected: mode_change with mode %0d, none expected", mode);
        end else begin
          exp_m = exp_q.pop_front();
          check("pulse_mode", {28'd0, mode}, {28'd0, exp_m});
        end
      end
      if (done) done_count++;
      if (state_dbg == ST_BLANK) blank_cycles++;
    end
  end

  // driver tasks
  task automatic send_req(input logic [3:0] m, input string name);
    bit acc;
    bit rdy;
    acc = 1'b0;
    @(negedge clk);
    req_mode  = m;
    req_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check({name, "_accept"}, {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_pulse(input string name);
    int i;
    i = 0;
    while (!mode_change && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({name, "_pulse_seen"}, {31'd0, mode_change}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 300) begin
      @(negedge clk);
      i++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic clear_mon();
    done_count   = 0;
    blank_cycles = 0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    int k;
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_WL};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_UB};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_ID};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, VGA_640x480p60, O_IDD};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, O_ID};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd0, O_ID};

    // reset, initial lock, same-mode request
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      pll_locked = vecs[i].lk;
      req_valid  = vecs[i].rv;
      req_mode   = vecs[i].rm;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {22'd0, obs()}, {22'd0, vecs[i].exp_o});
    end
    @(negedge clk);

    // mode change with a clean unlock/relock
    clear_mon();
    exp_q.push_back(MODE_1024x768);
    send_req(MODE_1024x768, "a");
    wait_pulse("a");
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    repeat (10) @(negedge clk);
    pll_locked = 1'b1;
    wait_done("a");
    check("a_unblank", {31'd0, vpg_blank}, 32'd0);
    check("a_mode", {28'd0, mode}, {28'd0, MODE_1024x768});
    @(negedge clk);
    check("a_blank_len", blank_cycles, 32'd8);
    check("a_done_once", done_count, 32'd1);
    check("a_pulses_left", exp_q.size(), 32'd0);
    check("a_idle", {30'd0, busy, err}, 32'd0);

    // request for the mode already in use
    clear_mon();
    send_req(MODE_1024x768, "b");
    check("b_done", {31'd0, done}, 32'd1);
    check("b_blank", {30'd0, vpg_blank, busy}, 32'd0);
    @(negedge clk);
    check("b_done_pulse", {31'd0, done}, 32'd0);
    check("b_mode", {28'd0, mode}, {28'd0, MODE_1024x768});

    // lock never returns: two tries, then safe-mode fallback
    clear_mon();
    exp_q.push_back(MODE_1440x900);
    exp_q.push_back(MODE_1440x900);
    exp_q.push_back(VGA_640x480p60);
    send_req(MODE_1440x900, "c");
    wait_pulse("c");
    pll_locked = 1'b0;
    k = 1;
    n = 0;
    while (k < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (mode_change) k++;
    end
    check("c_three_pulses", k, 32'd3);
    pll_locked = 1'b1;
    wait_done("c");
    check("c_err", {31'd0, err}, 32'd1);
    check("c_mode", {28'd0, mode}, {28'd0, VGA_640x480p60});
    @(negedge clk);
    check("c_pulses_left", exp_q.size(), 32'd0);
    check("c_err_sticky", {30'd0, err, busy}, 32'd2);

    // one-cycle lock glitch inside the stability window
    clear_mon();
    exp_q.push_back(MODE_1024x768);
    send_req(MODE_1024x768, "d");
    wait_pulse("d");
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("d_unblank_delay", n, 32'd6);
    @(negedge clk);
    check("d_err_cleared", {31'd0, err}, 32'd0);
    check("d_mode", {28'd0, mode}, {28'd0, MODE_1024x768});

    // reset in the middle of a sequence
    clear_mon();
    send_req(MODE_1280x1024, "e");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("e_reset_outputs", {22'd0, obs()}, {22'd0, O_WL});
    check("e_reset_state", {29'd0, state_dbg}, {29'd0, ST_WAIT_LOCK});
    reset = 1'b0;
    wait_done("e");
    @(negedge clk);
    check("e_idle", {22'd0, obs()}, {22'd0, O_ID});

    // fallback also fails -> FAIL, then restart with an equal mode
    clear_mon();
    exp_q.push_back(MODE_1920x1080);
    exp_q.push_back(MODE_1920x1080);
    exp_q.push_back(VGA_640x480p60);
    exp_q.push_back(VGA_640x480p60);
    send_req(MODE_1920x1080, "f");
    wait_pulse("f");
    pll_locked = 1'b0;
    n = 0;
    while (state_dbg != ST_FAIL && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("f_fail_state", {29'd0, state_dbg}, {29'd0, ST_FAIL});
    check("f_fail_outputs", {22'd0, obs()}, {22'd0, O_FL});
    @(negedge clk);
    check("f_pulses_left", exp_q.size(), 32'd0);
    check("f_no_done", done_count, 32'd0);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(VGA_640x480p60);
    send_req(VGA_640x480p60, "f2");
    check("f_restart_blank", {29'd0, state_dbg}, {29'd0, ST_BLANK});
    wait_done("f2");
    @(negedge clk);
    check("f_err_cleared", {31'd0, err}, 32'd0);
    check("f2_pulses_left", exp_q.size(), 32'd0);

`ifdef VPG_MODE_SEQ_QUEUE_EN
    // back-to-back requests with the one-entry buffer
    clear_mon();
    exp_q.push_back(MODE_720x480);
    exp_q.push_back(MODE_1280x1024);
    @(negedge clk);
    req_mode  = MODE_720x480;
    req_valid = 1'b1;
    @(negedge clk);
    req_mode = MODE_1280x1024;
    check("q_ready_busy", {30'd0, req_ready, busy}, 32'd3);
    @(negedge clk);
    req_mode = MODE_1920x1080;
    check("q_stall", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("q1");
    @(negedge clk);
    wait_done("q2");
    @(negedge clk);
    check("q_pulses_left", exp_q.size(), 32'd0);
    check("q_mode", {28'd0, mode}, {28'd0, MODE_1280x1024});
    check("q_dones", done_count, 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
